program_loader: RTL and testbench

//  Upstream feeder for the simple CPU's instruction memory.
//  - Accepts a program image byte-stream over a valid/ready handshake.
//  - Writes the bytes sequentially into the writable instruction memory.
//  - Checks a trailing checksum byte.
//  - Holds the CPU in reset until a good image is loaded, then releases it.

---
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: loads a program image into the CPU's instruction memory.
//
// Accepts DEPTH image bytes over a valid/ready handshake and writes each one,
// one cycle after it is accepted, to consecutive memory addresses starting at 0.
// A trailing checksum byte must bring the modulo-2**DATA_W sum of all bytes to
// zero. The CPU is held in reset until a good image has been loaded.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active low
//   start      request a (re)load; ignored while loading or checking
//   in_valid   upstream byte valid
//   in_data    upstream byte
//   in_ready   loader accepts a byte this cycle
//   we         instruction memory write enable (one cycle per accepted image byte)
//   waddr      instruction memory write address (holds when we is low)
//   wdata      instruction memory write data (holds when we is low)
//   cpu_rst_n  CPU reset; low holds the CPU in reset
//   busy       loading or checking
//   done       good image loaded, CPU running
//   err        checksum mismatch
module program_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StRun, StErr} state_e;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   sum_next;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                xfer;

  // Moore outputs decoded from the state register
  always_comb begin
    in_ready  = (state_q == StLoad) || (state_q == StCheck);
    busy      = in_ready;
    done      = (state_q == StRun);
    err       = (state_q == StErr);
    cpu_rst_n = (state_q == StRun);
  end

  assign xfer     = in_valid && in_ready;
  // Sum wraps naturally at DATA_W bits
  assign sum_next = sum_q + in_data;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      StIdle, StRun, StErr: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = '0;
          sum_d   = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = idx_q;
          wdata_d = in_data;
          sum_d   = sum_next;
          // DEPTH == 2**ADDR_W, so the increment wraps idx back to 0 on the last byte
          idx_d   = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (xfer) begin
          state_d = (sum_next == '0) ? StRun : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int Depth = 16;

  localparam int PIdle  = 0;
  localparam int PLoad  = 1;
  localparam int PCheck = 2;
  localparam int PRun   = 3;
  localparam int PErr   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, we, cpu_rst_n, busy, done, err;
  logic [3:0] waddr;
  logic [7:0] wdata;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_W(4),
    .DATA_W(8),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase of the load, bytes seen so far, running checksum,
  // and the memory write the previous cycle's accepted byte should produce.
  int   ph = PIdle;
  int   m_cnt = 0;
  int   m_sum = 0;
  bit   m_we = 0;
  int   m_waddr = 0;
  int   m_wdata = 0;
  bit   m_take = 0;
  bit   mon_en = 0;
  logic m_rdy;

  assign m_rdy = (ph == PLoad) || (ph == PCheck);

  always @(posedge clk) begin
    if (!rst) begin
      ph      = PIdle;
      m_cnt   = 0;
      m_sum   = 0;
      m_we    = 0;
      m_waddr = 0;
      m_wdata = 0;
      mon_en  = 1;
    end else begin
      m_take = in_valid && m_rdy;
      m_we   = 0;
      if (ph == PLoad) begin
        if (m_take) begin
          m_we    = 1;
          m_waddr = m_cnt;
          m_wdata = int'(in_data);
          m_sum   = (m_sum + int'(in_data)) % 256;
          m_cnt   = m_cnt + 1;
          if (m_cnt == Depth) begin
            m_cnt = 0;
            ph    = PCheck;
          end
        end
      end else if (ph == PCheck) begin
        if (m_take) ph = (((m_sum + int'(in_data)) % 256) == 0) ? PRun : PErr;
      end else if (start) begin
        ph    = PLoad;
        m_cnt = 0;
        m_sum = 0;
      end
    end
  end

  // Shadow of the instruction memory, written from the DUT's write port
  logic [7:0] tb_mem [Depth];
  logic [7:0] img [Depth];

  always @(negedge clk) begin
    if (mon_en) begin
      check("ctl", 32'({in_ready, busy, done, err, cpu_rst_n, we}),
            32'({m_rdy, m_rdy, ph == PRun, ph == PErr, ph == PRun, m_we}));
      check("waddr", 32'(waddr), 32'(m_waddr));
      check("wdata", 32'(wdata), 32'(m_wdata));
      if (we) tb_mem[waddr] = wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: idle cycle after each byte, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int tries = 0;
    bit taken = 0;
    while (!taken && tries < 200) begin
      in_valid = (mode == 2) ? ($urandom_range(99) >= 40) : 1'b1;
      in_data  = b;
      @(negedge clk);
      taken = in_valid && m_rdy;
      tick();
      tries++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!taken) check("handshake_timeout", 32'(0), 32'(1));
    if (mode == 1) tick();
  endtask

  task automatic send_bytes(input int n, input int mode, input bit hold_start);
    if (hold_start) start = 1'b1;
    for (int i = 0; i < n; i++) send_byte(img[i], mode);
    start = 1'b0;
  endtask

  function automatic logic [7:0] good_chk();
    int s = 0;
    for (int i = 0; i < Depth; i++) s += int'(img[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic send_image(input logic [7:0] chk, input int mode, input bit hold_start);
    send_bytes(Depth, mode, hold_start);
    send_byte(chk, mode);
    tick();
    tick();
  endtask

  task automatic check_result(input bit good);
    check("result", 32'({done, err, cpu_rst_n, busy}), good ? 32'b1010 : 32'b0100);
    if (good) begin
      for (int i = 0; i < Depth; i++) check("mem", 32'(tb_mem[i]), 32'(img[i]));
    end
  endtask

  initial begin
    logic [7:0] chk;
    bit good;

    for (int i = 0; i < Depth; i++) tb_mem[i] = 8'h00;

    // Reset held, then released with start low
    tick();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    check("idle_outs", 32'({in_ready, we, cpu_rst_n, busy, done, err}), 32'(0));

    // Counting image with good checksum
    for (int i = 0; i < Depth; i++) img[i] = 8'(i);
    pulse_start();
    send_image(8'h88, 0, 1'b0);
    check_result(1'b1);

    // Bad checksum, then reload with the good one
    pulse_start();
    send_image(8'h00, 0, 1'b0);
    check_result(1'b0);
    pulse_start();
    send_image(8'h88, 0, 1'b0);
    check_result(1'b1);

    // Valid every other cycle
    for (int i = 0; i < Depth; i++) img[i] = 8'($urandom);
    pulse_start();
    send_image(good_chk(), 1, 1'b0);
    check_result(1'b1);

    // Reset after the 8th byte, then a full reload
    pulse_start();
    send_bytes(8, 0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid", 32'({we, busy, cpu_rst_n, waddr}), 32'(0));
    for (int i = 0; i < Depth; i++) img[i] = 8'($urandom);
    pulse_start();
    send_image(good_chk(), 0, 1'b0);
    check_result(1'b1);

    // From RUN, start holds the CPU in reset; start held during load is ignored
    start = 1'b1;
    tick();
    check("reload_entry", 32'({cpu_rst_n, busy}), 32'b01);
    send_image(good_chk(), 0, 1'b1);
    check_result(1'b1);

    // Randomized images, gaps, checksums and mid-load resets
    repeat (40) begin
      for (int i = 0; i < Depth; i++) img[i] = 8'($urandom);
      good = ($urandom_range(3) != 0);
      chk  = good ? good_chk() : good_chk() ^ 8'($urandom_range(255, 1));
      pulse_start();
      if ($urandom_range(4) == 0) begin
        send_bytes($urandom_range(Depth - 1, 1), 2, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulse_start();
      end
      send_image(chk, $urandom_range(2), 1'($urandom_range(1)));
      check_result(good);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
